// File: rtl/z_core_lsu_axil.sv
// AXI4-Lite master load/store unit for the Z-Core multicycle control unit (fetch + data).
// Optional watchdog: define Z_CORE_LSU_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module z_core_lsu_axil #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_instr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int OFF_W = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return off[1:0] != 2'b00;
      default: return off != '0;
    endcase
  endfunction

  function automatic logic [STRB_WIDTH-1:0] strb_for(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [STRB_WIDTH-1:0] base;
    case (size)
      2'd0:    base = STRB_WIDTH'(1);
      2'd1:    base = STRB_WIDTH'(3);
      2'd2:    base = STRB_WIDTH'(15);
      default: base = STRB_WIDTH'(255);
    endcase
    return base << off;
  endfunction

  // Left-justify the field then shift back down, arithmetic for signed loads.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] size, input logic uns);
    logic signed [DATA_WIDTH-1:0] t;
    int sh;
    sh = DATA_WIDTH - (8 << size);
    if (sh <= 0) return d;
    t = d << sh;
    if (uns) return $unsigned(t) >> sh;
    return $unsigned(t >>> sh);
  endfunction

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [2:0]            arprot_q, arprot_d, awprot_q, awprot_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  req_bad;
  logic                  unused_resp;

`ifdef Z_CORE_LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

  assign aligned_addr = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign req_bad      = is_misaligned(req_size, req_addr[OFF_W-1:0]) ||
                        ((req_size == 2'd3) && (DATA_WIDTH == 32));
  assign unused_resp  = m_axil_rresp[0] ^ m_axil_bresp[0];

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    awprot_d     = awprot_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
`ifdef Z_CORE_LSU_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[OFF_W-1:0];
`ifdef Z_CORE_LSU_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we) begin
            state_d   = AW_W;
            awaddr_d  = aligned_addr;
            awprot_d  = {req_instr, 2'b00};
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
            wstrb_d   = strb_for(req_size, req_addr[OFF_W-1:0]);
          end else begin
            state_d   = AR;
            araddr_d  = aligned_addr;
            arprot_d  = {req_instr, 2'b00};
            arvalid_d = 1'b1;
          end
        end
      end
      AR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (m_axil_rvalid) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = m_axil_rresp[1];
          resp_rdata_d = m_axil_rresp[1] ? '0 :
                         load_extend(m_axil_rdata >> {off_q, 3'b000}, size_q, uns_q);
          state_d      = RESP;
        end
      end
      AW_W: begin
        // Address and data channels retire independently; move on once both are done.
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
          bready_d = 1'b1;
          state_d  = B;
        end
      end
      B: begin
        if (m_axil_bvalid) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = m_axil_bresp[1];
          resp_rdata_d = '0;
          state_d      = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef Z_CORE_LSU_TIMEOUT_EN
    if (state_q == AR || state_q == R || state_q == AW_W || state_q == B) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d      = RESP;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      araddr_q     <= '0;
      arprot_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awprot_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef Z_CORE_LSU_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      araddr_q     <= araddr_d;
      arprot_q     <= arprot_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      awprot_q     <= awprot_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef Z_CORE_LSU_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = awprot_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_z_core_lsu_axil.sv
// Directed bench for z_core_lsu_axil (32-bit data) with a cycle-stepped AXI4-Lite slave.
// Timeout scenario is exercised only when Z_CORE_LSU_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_z_core_lsu_axil;

  logic        clk, rstn;
  logic        req_valid, req_ready, req_we, req_instr, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by run_req
  int          o_ar_cyc, o_ar_cnt, o_aw_cnt, o_w_cnt, o_resp_cnt, o_resp_cyc, o_wait;
  logic        o_ar_seen, o_err;
  logic [31:0] o_araddr, o_awaddr, o_wdata, o_rdata, o_rdata_hold;
  logic [2:0]  o_arprot;
  logic [3:0]  o_wstrb;

  z_core_lsu_axil #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_instr(req_instr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request; cycle 0 is the accept cycle. The slave waits *_dly valid cycles before ready.
  task automatic run_req(input logic we, input logic instr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int aw_dly, input int w_dly, input int ar_dly,
                         input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                         input int linger);
    bit done;
    o_ar_cyc = -1; o_ar_cnt = 0; o_aw_cnt = 0; o_w_cnt = 0; o_resp_cnt = 0; o_resp_cyc = -1;
    o_ar_seen = 1'b0; o_err = 1'bx; o_araddr = 'x; o_awaddr = 'x; o_wdata = 'x; o_rdata = 'x;
    o_rdata_hold = 'x; o_arprot = 'x; o_wstrb = 'x; o_wait = 0; done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_instr = instr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    while (!req_ready && o_wait < 20) begin
      @(negedge clk);
      o_wait++;
    end
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (arvalid) begin
        if (!o_ar_seen) begin o_ar_cyc = c; o_araddr = araddr; o_arprot = arprot; end
        o_ar_seen = 1'b1;
        o_ar_cnt++;
      end
      if (awvalid) begin o_aw_cnt++; o_awaddr = awaddr; end
      if (wvalid) begin o_w_cnt++; o_wdata = wdata; o_wstrb = wstrb; end
      if (resp_valid) begin
        o_resp_cnt++;
        if (o_resp_cnt == 1) begin o_resp_cyc = c; o_rdata = resp_rdata; o_err = resp_err; end
      end
      if (o_resp_cnt > 0 && c >= o_resp_cyc + linger) begin
        o_rdata_hold = resp_rdata;
        done = 1'b1;
      end
      arready = arvalid && (o_ar_cnt > ar_dly);
      awready = awvalid && (o_aw_cnt > aw_dly);
      wready  = wvalid && (o_w_cnt > w_dly);
      rvalid  = rready;
      rdata   = rready ? rd : 32'h0;
      rresp   = rr;
      bvalid  = bready;
      bresp   = br;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_instr = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready} !== 8'h00) begin
      n_fail++; $display("FAIL rst_ctrl got %b want 00000000",
        {req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready});
    end
    n_tests++;
    if ({resp_rdata, araddr, awaddr, wdata, wstrb, arprot, awprot} !== '0) begin
      n_fail++; $display("FAIL rst_data got rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%h want 0",
        resp_rdata, araddr, awaddr, wdata, wstrb);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_load_word();
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00, 3);
    n_tests++; if (o_ar_cyc !== 1) begin n_fail++; $display("FAIL ldw_ar_cyc got %0d want 1", o_ar_cyc); end
    n_tests++; if (o_araddr !== 32'h100) begin n_fail++; $display("FAIL ldw_araddr got %h want 00000100", o_araddr); end
    n_tests++; if (o_arprot !== 3'b000) begin n_fail++; $display("FAIL ldw_arprot got %b want 000", o_arprot); end
    n_tests++; if (o_resp_cyc !== 3) begin n_fail++; $display("FAIL ldw_resp_cyc got %0d want 3", o_resp_cyc); end
    n_tests++; if (o_resp_cnt !== 1) begin n_fail++; $display("FAIL ldw_resp_cnt got %0d want 1", o_resp_cnt); end
    n_tests++; if (o_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_rdata got %h want deadbeef", o_rdata); end
    n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL ldw_err got %b want 0", o_err); end
    n_tests++; if (o_rdata_hold !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_hold got %h want deadbeef", o_rdata_hold); end
  endtask

  task automatic test_load_ext();
    run_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 0, 32'h80112233, 2'b00, 2'b00, 1);
    n_tests++; if (o_araddr !== 32'h100) begin n_fail++; $display("FAIL ldb_araddr got %h want 00000100", o_araddr); end
    n_tests++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL ldb_signed got %h want ffffff80", o_rdata); end
    run_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 0, 32'h80112233, 2'b00, 2'b00, 1);
    n_tests++; if (o_rdata !== 32'h00000080) begin n_fail++; $display("FAIL ldbu got %h want 00000080", o_rdata); end
    run_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 0, 0, 32'h80112233, 2'b00, 2'b00, 1);
    n_tests++; if (o_rdata !== 32'hFFFF8011) begin n_fail++; $display("FAIL ldh_signed got %h want ffff8011", o_rdata); end
    run_req(1'b0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, 0, 0, 32'h80112233, 2'b00, 2'b00, 1);
    n_tests++; if (o_rdata !== 32'h00008011) begin n_fail++; $display("FAIL ldhu got %h want 00008011", o_rdata); end
    run_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, 0, 2, 32'h80112233, 2'b00, 2'b00, 1);
    n_tests++; if (o_rdata !== 32'h00000022) begin n_fail++; $display("FAIL ldb_pos got %h want 00000022", o_rdata); end
    n_tests++; if (o_ar_cnt !== 3) begin n_fail++; $display("FAIL ldb_ar_hold got %0d want 3", o_ar_cnt); end
  endtask

  task automatic test_store();
    run_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h06, 32'h0000ABCD, 3, 0, 0, 32'h0, 2'b00, 2'b00, 1);
    n_tests++; if (o_awaddr !== 32'h04) begin n_fail++; $display("FAIL sth_awaddr got %h want 00000004", o_awaddr); end
    n_tests++; if (o_wdata !== 32'hABCD0000) begin n_fail++; $display("FAIL sth_wdata got %h want abcd0000", o_wdata); end
    n_tests++; if (o_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sth_wstrb got %b want 1100", o_wstrb); end
    n_tests++; if (o_w_cnt !== 1) begin n_fail++; $display("FAIL sth_wvalid_cycles got %0d want 1", o_w_cnt); end
    n_tests++; if (o_aw_cnt !== 4) begin n_fail++; $display("FAIL sth_awvalid_cycles got %0d want 4", o_aw_cnt); end
    n_tests++; if (o_resp_cnt !== 1) begin n_fail++; $display("FAIL sth_resp_cnt got %0d want 1", o_resp_cnt); end
    n_tests++; if ({o_err, o_rdata} !== 33'h0) begin n_fail++; $display("FAIL sth_resp got err=%b rdata=%h want 0", o_err, o_rdata); end
    run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0000005A, 0, 2, 0, 32'h0, 2'b00, 2'b00, 1);
    n_tests++; if (o_wdata !== 32'h00005A00) begin n_fail++; $display("FAIL stb_wdata got %h want 00005a00", o_wdata); end
    n_tests++; if (o_wstrb !== 4'b0010) begin n_fail++; $display("FAIL stb_wstrb got %b want 0010", o_wstrb); end
    n_tests++; if ({o_aw_cnt, o_w_cnt} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL stb_valid_cycles got aw=%0d w=%0d want aw=1 w=3", o_aw_cnt, o_w_cnt); end
    run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h12345678, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1);
    n_tests++; if ({o_wdata, o_wstrb} !== {32'h12345678, 4'b1111}) begin n_fail++; $display("FAIL stw got wdata=%h wstrb=%b want 12345678/1111", o_wdata, o_wstrb); end
    n_tests++; if (o_resp_cyc !== 3) begin n_fail++; $display("FAIL stw_resp_cyc got %0d want 3", o_resp_cyc); end
  endtask

  task automatic test_errors();
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, 0, 32'h11111111, 2'b00, 2'b00, 2);
    n_tests++; if (o_ar_seen !== 1'b0) begin n_fail++; $display("FAIL mis_arvalid got %b want 0", o_ar_seen); end
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b want 1", o_err); end
    n_tests++; if (o_resp_cyc < 1 || o_resp_cyc > 2) begin n_fail++; $display("FAIL mis_resp_cyc got %0d want 1..2", o_resp_cyc); end
    n_tests++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", o_rdata); end
    run_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 2);
    n_tests++; if ({o_err, o_aw_cnt} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL illsize got err=%b aw=%0d want err=1 aw=0", o_err, o_aw_cnt); end
    run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 0, 0, 0, 32'h0, 2'b00, 2'b10, 1);
    n_tests++; if ({o_err, o_resp_cnt} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL slverr_st got err=%b cnt=%0d want err=1 cnt=1", o_err, o_resp_cnt); end
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 0, 0, 32'h55AA55AA, 2'b11, 2'b00, 1);
    n_tests++; if ({o_err, o_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL decerr_ld got err=%b rdata=%h want err=1 rdata=0", o_err, o_rdata); end
  endtask

  task automatic test_fetch();
    run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 0, 0, 0, 32'h00000013, 2'b00, 2'b00, 1);
    n_tests++; if (o_arprot !== 3'b100) begin n_fail++; $display("FAIL fetch_arprot got %b want 100", o_arprot); end
    n_tests++; if (o_rdata !== 32'h00000013) begin n_fail++; $display("FAIL fetch_rdata got %h want 00000013", o_rdata); end
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 2'b00, 0);
    n_tests++; if (o_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_first got %h want a5a5a5a5", o_rdata); end
    run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h43, 32'h000000EE, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1);
    n_tests++; if (o_wait !== 0) begin n_fail++; $display("FAIL b2b_accept_wait got %0d want 0", o_wait); end
    n_tests++; if ({o_wdata, o_wstrb} !== {32'hEE000000, 4'b1000}) begin n_fail++; $display("FAIL b2b_store got wdata=%h wstrb=%b want ee000000/1000", o_wdata, o_wstrb); end
  endtask

  task automatic test_reset_mid();
    int k;
    int resp_seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_instr = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_unsigned = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    k = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      arready = arvalid;
      rvalid = 1'b0;
      k++;
    end while (!rready && k < 20);
    n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_r got rready=%b want 1", rready); end
    arready = 1'b0;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready, resp_rdata, araddr} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got ctrl=%b rdata=%h araddr=%h want 0",
        {req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready}, resp_rdata, araddr);
    end
    resp_seen = 0;
    repeat (2) begin @(negedge clk); if (resp_valid) resp_seen++; end
    rstn = 1'b1;
    repeat (5) begin @(negedge clk); if (resp_valid) resp_seen++; end
    n_tests++; if (resp_seen !== 0) begin n_fail++; $display("FAIL rstmid_resp got %0d pulses want 0", resp_seen); end
  endtask

`ifdef Z_CORE_LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 0, 0, 1000, 32'h0, 2'b00, 2'b00, 1);
    n_tests++; if (o_ar_cnt !== 8) begin n_fail++; $display("FAIL tmo_ar_cycles got %0d want 8", o_ar_cnt); end
    n_tests++; if (o_resp_cyc !== 9) begin n_fail++; $display("FAIL tmo_resp_cyc got %0d want 9", o_resp_cyc); end
    n_tests++; if ({o_err, o_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL tmo_resp got err=%b rdata=%h want err=1 rdata=0", o_err, o_rdata); end
    n_tests++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL tmo_arvalid got %b want 0", arvalid); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_errors();
    test_fetch();
    test_back_to_back();
    test_reset_mid();
`ifdef Z_CORE_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
